mdu_ctrl: RTL and testbench
===========================

Name: mdu_ctrl

Overview:
- Multi-cycle multiply/divide unit controller. Owns the architectural HI/LO pair and moves MULT/MULTU/DIV/DIVU off the combinational ALU path.
- Takes one operation per handshake from the decode/execute stage, runs a multiply latency counter or a radix-2 restoring divider, and commits results atomically to HI/LO.
- Stalls the pipeline when an MFHI/MFLO/MTHI/MTLO or a new start hits an in-flight operation.

Parameters:
- XLEN, 32, operand width; only 32 is supported.
- MUL_LATENCY, 3, cycles from multiply acceptance to HI/LO commit; range 1..8.

Ports:
- clk  in  1  rising-edge clock
- reset_ni  in  1  asynchronous active-low reset
- start_i  in  1  request to issue op_i
- op_i  in  mdu_op_t  MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU, MDU_MTHI, MDU_MTLO
- rs_i  in  32  operand A (dividend / multiplicand / MTHI-MTLO source)
- rt_i  in  32  operand B (divisor / multiplier)
- mf_req_i  in  1  an MFHI or MFLO is in execute this cycle
- busy_o  out  1  an operation is in flight
- stall_o  out  1  execute stage must hold
- done_o  out  1  one-cycle pulse on HI/LO commit
- hi_o  out  32  HI register
- lo_o  out  32  LO register

Behaviour:
- Reset (async assert, sync deassert): state IDLE; HI=LO=0; busy_o=0, done_o=0, stall_o=0; counters cleared.
- Reset mid-operation aborts the operation. No partial result is committed.
- States are IDLE, MUL, DIV, FIX.
- IDLE:
  - start_i with MULT/MULTU: latch signed or unsigned 64-bit product; go to MUL with cnt=MUL_LATENCY-1.
  - start_i with DIV/DIVU and rt_i!=0: latch |rs|,|rt| (signed) or raw operands and the result signs; go to DIV with step=31.
  - start_i with DIV/DIVU and rt_i==0: go directly to FIX with HI=LO=0 staged.
  - start_i with MTHI/MTLO: write HI or LO at this clock edge; stay in IDLE. done_o is not pulsed.
- MUL: decrement cnt. At cnt==0, commit HI/LO from the product and return to IDLE. Busy for exactly MUL_LATENCY cycles after acceptance.
- DIV: one restoring step per cycle (shift remainder, trial subtract, set quotient bit). At step==0 go to FIX.
- FIX: negate the quotient if the operand signs differ; negate the remainder if the dividend is negative (signed only). Commit LO=quotient, HI=remainder; return to IDLE.
- DIV/DIVU is busy for 33 cycles after acceptance; divide-by-zero is busy for 1 cycle.
- 0x80000000 / -1 (signed) gives LO=0x80000000, HI=0. No exception is raised.
- done_o pulses in the cycle after the commit edge, i.e. when HI/LO first show the new value.
- busy_o = (state != IDLE).
- stall_o = busy_o & (start_i | mf_req_i).
  - An op is never accepted while busy; the requester holds start_i/op_i stable.
  - Combinationally, stall_o clears in the cycle done_o rises. The held start is accepted that cycle, and the MF reads the committed value.
- hi_o/lo_o are registered. They change only on a commit or an MT write, never mid-operation.

Optional Feature:
- MDU_ABORT_EN defined:
  - Adds input abort_i (1 bit), used for exception/branch-flush cancellation of an in-flight op.
  - abort_i while busy returns to IDLE at the next edge. HI/LO keep their pre-op values; no done_o.
  - abort_i takes priority over a same-cycle commit. abort_i in IDLE has no effect; the same-cycle start_i is still honoured.
- MDU_ABORT_EN undefined: the port is absent and operations always run to completion.

Decomposition:
- Package codes gains:
  - mdu_op_t enum
  - mdu_state_t enum
  - MDU_DIV_STEPS=32 constant
- Sub-module mdu_div_step: combinational single restoring iteration.
  - In: remainder, quotient, divisor. Out: next remainder, next quotient.
  - Instantiated once and driven from the DIV state.

Test Plan:
- MULT rs=0xFFFFFFFF, rt=2, MUL_LATENCY=3 -> busy_o 3 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE, done_o single pulse.
- MULTU with the same operands -> HI=0x00000001, LO=0xFFFFFFFE.
- DIV rs=-7 (0xFFFFFFF9), rt=2 -> busy 33 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 100/7 -> LO=14, HI=2.
- DIVU rs=100, rt=0 -> busy 1 cycle, HI=LO=0. DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- Start DIV 50/5, assert mf_req_i on cycle 2 -> stall_o high until the done_o cycle, HI=0, LO=10 visible that cycle. MTHI 0x1234 during busy -> stalled, then applied.
- Drop reset_ni mid-DIV (cycle 10) -> busy_o=0 and HI=LO=0 immediately. With MDU_ABORT_EN, abort_i at cycle 10 -> HI/LO keep their prior values and no done_o.

Source files
------------

// File: rtl/mdu_ctrl_pkg.sv
// rtl/mdu_ctrl_pkg.sv - shared types and constants for the multiply/divide unit
package mdu_ctrl_pkg;

    localparam int MDU_DIV_STEPS = 32;

    typedef enum logic [2:0] {
        MDU_MULT  = 3'd0,
        MDU_MULTU = 3'd1,
        MDU_DIV   = 3'd2,
        MDU_DIVU  = 3'd3,
        MDU_MTHI  = 3'd4,
        MDU_MTLO  = 3'd5
    } mdu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } mdu_state_t;

endpackage

// File: rtl/mdu_div_step.sv
// rtl/mdu_div_step.sv - one combinational radix-2 restoring divide iteration
module mdu_div_step (
    input  logic [31:0] rem_i,
    input  logic [31:0] quo_i,
    input  logic [31:0] div_i,
    output logic [31:0] rem_o,
    output logic [31:0] quo_o
);

    logic [32:0] shifted;
    logic [32:0] trial;

    // Shift the next dividend bit into the remainder, keep the trial difference if non-negative
    always_comb begin
        shifted = {rem_i, quo_i[31]};
        trial   = shifted - {1'b0, div_i};
        if (!trial[32]) begin
            rem_o = trial[31:0];
            quo_o = {quo_i[30:0], 1'b1};
        end else begin
            rem_o = shifted[31:0];
            quo_o = {quo_i[30:0], 1'b0};
        end
    end

endmodule

// File: rtl/mdu_ctrl.sv
// rtl/mdu_ctrl.sv - multi-cycle MDU controller owning HI/LO; MDU_ABORT_EN adds abort_i flush input
module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int MUL_LATENCY = 3
) (
    input  logic            clk,
    input  logic            reset_ni,
    input  logic            start_i,
    input  mdu_op_t         op_i,
    input  logic [XLEN-1:0] rs_i,
    input  logic [XLEN-1:0] rt_i,
    input  logic            mf_req_i,
`ifdef MDU_ABORT_EN
    input  logic            abort_i,
`endif
    output logic            busy_o,
    output logic            stall_o,
    output logic            done_o,
    output logic [XLEN-1:0] hi_o,
    output logic [XLEN-1:0] lo_o
);

    logic abort;
`ifdef MDU_ABORT_EN
    assign abort = abort_i;
`else
    assign abort = 1'b0;
`endif

    mdu_state_t        state_q, state_d;
    logic [4:0]        cnt_q;
    logic [XLEN-1:0]   rem_q, quo_q, dvs_q, hi_q, lo_q;
    logic              neg_q_q, neg_r_q, done_q;
    logic [XLEN-1:0]   rem_nx, quo_nx;
    logic              is_mul, is_div, is_signed;
    logic signed [2*XLEN-1:0] rs_sx, rt_sx;
    logic [2*XLEN-1:0] mul_p;
    logic [XLEN-1:0]   rs_abs, rt_abs;

    mdu_div_step u_div_step (
        .rem_i (rem_q),
        .quo_i (quo_q),
        .div_i (dvs_q),
        .rem_o (rem_nx),
        .quo_o (quo_nx)
    );

    // Operand decode: product, magnitudes for the divider
    always_comb begin
        is_mul    = (op_i == MDU_MULT) || (op_i == MDU_MULTU);
        is_div    = (op_i == MDU_DIV)  || (op_i == MDU_DIVU);
        is_signed = (op_i == MDU_MULT) || (op_i == MDU_DIV);
        rs_sx     = {{XLEN{rs_i[XLEN-1]}}, rs_i};
        rt_sx     = {{XLEN{rt_i[XLEN-1]}}, rt_i};
        if (is_signed) mul_p = rs_sx * rt_sx;
        else           mul_p = {{XLEN{1'b0}}, rs_i} * {{XLEN{1'b0}}, rt_i};
        rs_abs    = (is_signed && rs_i[XLEN-1]) ? -rs_i : rs_i;
        rt_abs    = (is_signed && rt_i[XLEN-1]) ? -rt_i : rt_i;
    end

    // State register
    always_ff @(posedge clk or negedge reset_ni) begin
        if (!reset_ni) state_q <= ST_IDLE;
        else           state_q <= state_d;
    end

    // Next-state logic; abort wins over a same-cycle commit
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i && is_mul)      state_d = ST_MUL;
                else if (start_i && is_div) state_d = (rt_i == '0) ? ST_FIX : ST_DIV;
            end
            ST_MUL:  if (abort || cnt_q == 5'd0) state_d = ST_IDLE;
            ST_DIV: begin
                if (abort)              state_d = ST_IDLE;
                else if (cnt_q == 5'd0) state_d = ST_FIX;
            end
            ST_FIX:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Handshake outputs
    always_comb begin
        busy_o  = (state_q != ST_IDLE);
        stall_o = busy_o && (start_i || mf_req_i);
        done_o  = done_q;
        hi_o    = hi_q;
        lo_o    = lo_q;
    end

    // Datapath: operand capture, divide steps, HI/LO commit and MT writes
    always_ff @(posedge clk or negedge reset_ni) begin
        if (!reset_ni) begin
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            neg_q_q <= 1'b0;
            neg_r_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        case (op_i)
                            MDU_MULT, MDU_MULTU: begin
                                // rem/quo double as the product holding register
                                rem_q <= mul_p[2*XLEN-1:XLEN];
                                quo_q <= mul_p[XLEN-1:0];
                                cnt_q <= 5'(MUL_LATENCY - 1);
                            end
                            MDU_DIV, MDU_DIVU: begin
                                rem_q   <= '0;
                                cnt_q   <= 5'(MDU_DIV_STEPS - 1);
                                if (rt_i == '0) begin
                                    quo_q   <= '0;
                                    dvs_q   <= '0;
                                    neg_q_q <= 1'b0;
                                    neg_r_q <= 1'b0;
                                end else begin
                                    quo_q   <= rs_abs;
                                    dvs_q   <= rt_abs;
                                    neg_q_q <= is_signed && (rs_i[XLEN-1] ^ rt_i[XLEN-1]);
                                    neg_r_q <= is_signed && rs_i[XLEN-1];
                                end
                            end
                            MDU_MTHI: hi_q <= rs_i;
                            MDU_MTLO: lo_q <= rs_i;
                            default: ;
                        endcase
                    end
                end
                ST_MUL: begin
                    if (!abort) begin
                        if (cnt_q == 5'd0) begin
                            hi_q   <= rem_q;
                            lo_q   <= quo_q;
                            done_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q - 5'd1;
                        end
                    end
                end
                ST_DIV: begin
                    rem_q <= rem_nx;
                    quo_q <= quo_nx;
                    cnt_q <= cnt_q - 5'd1;
                end
                ST_FIX: begin
                    if (!abort) begin
                        lo_q   <= neg_q_q ? -quo_q : quo_q;
                        hi_q   <= neg_r_q ? -rem_q : rem_q;
                        done_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb/tb_mdu_ctrl.sv - randomized self-checking bench for mdu_ctrl against a behavioural model
`timescale 1ns/1ps
module tb_mdu_ctrl;
    import mdu_ctrl_pkg::*;

    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        mf_req = 1'b0;
    logic        abort = 1'b0;
    mdu_op_t     op = MDU_MULT;
    logic [31:0] rs = '0;
    logic [31:0] rt = '0;
    logic        busy, stall, done;
    logic [31:0] hi, lo;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    mdu_ctrl #(.XLEN(32), .MUL_LATENCY(LAT)) dut (
        .clk      (clk),
        .reset_ni (rst_n),
        .start_i  (start),
        .op_i     (op),
        .rs_i     (rs),
        .rt_i     (rt),
        .mf_req_i (mf_req),
`ifdef MDU_ABORT_EN
        .abort_i  (abort),
`endif
        .busy_o   (busy),
        .stall_o  (stall),
        .done_o   (done),
        .hi_o     (hi),
        .lo_o     (lo)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Architectural result {HI, LO} from plain arithmetic
    function automatic logic [63:0] ref_result(input mdu_op_t o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] u;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            MDU_MULT:  begin q = sa * sb; return q; end
            MDU_MULTU: begin u = {32'b0, a} * {32'b0, b}; return u; end
            MDU_DIV: begin
                if (b == 0) return 64'd0;
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            MDU_DIVU: begin
                if (b == 0) return 64'd0;
                return {a % b, a / b};
            end
            default: return 64'd0;
        endcase
    endfunction

    // Model: remaining busy cycles, pending result, architectural HI/LO
    int          m_left = 0;
    logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
    logic        m_done = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left = 0; m_hi = '0; m_lo = '0; m_done = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_left > 0) begin
                if (abort) m_left = 0;
                else begin
                    m_left--;
                    if (m_left == 0) begin m_hi = p_hi; m_lo = p_lo; m_done = 1'b1; end
                end
            end else if (start) begin
                case (op)
                    MDU_MTHI: m_hi = rs;
                    MDU_MTLO: m_lo = rs;
                    MDU_MULT, MDU_MULTU: begin {p_hi, p_lo} = ref_result(op, rs, rt); m_left = LAT; end
                    MDU_DIV, MDU_DIVU: begin {p_hi, p_lo} = ref_result(op, rs, rt); m_left = (rt == 0) ? 1 : 33; end
                    default: ;
                endcase
            end
        end
    end

    // Cycle-by-cycle comparison away from the active edge
    always @(negedge clk) begin
        if (rst_n) begin
            chk("busy", busy, m_left > 0);
            chk("done", done, m_done);
            chk("stall", stall, (m_left > 0) && (start || mf_req));
            chk("hi", hi, m_hi);
            chk("lo", lo, m_lo);
        end
    end

    // Present an op and hold it until the edge that accepts it
    task automatic issue(input mdu_op_t o, input logic [31:0] a, input logic [31:0] b);
        logic was_busy;
        bit   ok;
        ok = 1'b0;
        @(negedge clk); #2;
        start = 1'b1; op = o; rs = a; rt = b;
        for (int i = 0; i < 200; i++) begin
            was_busy = busy;
            @(posedge clk);
            if (!was_busy) begin ok = 1'b1; break; end
            @(negedge clk); #2;
        end
        if (!ok) chk("accept_timeout", 0, 1);
        #1 start = 1'b0;
    endtask

    task automatic run_lit(input string name, input mdu_op_t o, input logic [31:0] a, input logic [31:0] b,
                           input int exp_busy, input logic [31:0] eh, input logic [31:0] el);
        logic [63:0] r;
        int nb;
        bit seen;
        r = ref_result(o, a, b);
        chk({name, "_model_hi"}, r[63:32], eh);
        chk({name, "_model_lo"}, r[31:0], el);
        issue(o, a, b);
        nb = 0; seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (busy) nb++;
            if (done) begin seen = 1'b1; break; end
        end
        chk({name, "_done_seen"}, seen, 1);
        chk({name, "_busy_cycles"}, nb, exp_busy);
        chk({name, "_hi"}, hi, eh);
        chk({name, "_lo"}, lo, el);
        @(negedge clk);
        chk({name, "_done_single"}, done, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, b;
        repeat (3) @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_hi", hi, 0);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("idle_done", done, 0);

        run_lit("mult",    MDU_MULT,  32'hFFFFFFFF, 32'd2, LAT, 32'hFFFFFFFF, 32'hFFFFFFFE);
        run_lit("multu",   MDU_MULTU, 32'hFFFFFFFF, 32'd2, LAT, 32'h00000001, 32'hFFFFFFFE);
        run_lit("div_neg", MDU_DIV,   32'hFFFFFFF9, 32'd2, 33,  32'hFFFFFFFF, 32'hFFFFFFFD);
        run_lit("divu",    MDU_DIVU,  32'd100,      32'd7, 33,  32'd2,        32'd14);
        run_lit("divu_z",  MDU_DIVU,  32'd100,      32'd0, 1,   32'd0,        32'd0);
        run_lit("div_ovf", MDU_DIV,   32'h80000000, 32'hFFFFFFFF, 33, 32'd0,  32'h80000000);

        // MF read during a divide stalls until the commit is visible
        issue(MDU_DIV, 32'd50, 32'd5);
        @(negedge clk); #2 mf_req = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (done) break;
        end
        chk("mf_done", done, 1);
        chk("mf_stall_clear", stall, 0);
        chk("mf_hi", hi, 0);
        chk("mf_lo", lo, 10);
        #2 mf_req = 1'b0;

        // MTHI presented while busy is held off, then applied
        issue(MDU_DIVU, 32'd100, 32'd7);
        issue(MDU_MTHI, 32'h1234, 32'd0);
        @(negedge clk);
        chk("mthi_hi", hi, 32'h1234);
        chk("mthi_lo", lo, 14);

`ifdef MDU_ABORT_EN
        issue(MDU_MTLO, 32'h22, 32'd0);
        issue(MDU_DIV, 32'd50, 32'd5);
        repeat (9) @(negedge clk);
        #2 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_hi", hi, 32'h1234);
        chk("abort_lo", lo, 32'h22);
        issue(MDU_MULT, 32'd6, 32'd7);
        repeat (LAT) @(negedge clk);
        #2 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        @(negedge clk);
        chk("abort_commit_lo", lo, 32'h22);
        abort = 1'b1;
        issue(MDU_MTLO, 32'h33, 32'd0);
        abort = 1'b0;
        @(negedge clk);
        chk("abort_idle_mt", lo, 32'h33);
`endif

        // Randomized ops with random MF traffic and back-to-back issue
        for (int n = 0; n < 60; n++) begin
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: b = 32'hFFFFFFFF;
                2: b = $urandom_range(1, 9);
                3: a = 32'h80000000;
                default: ;
            endcase
            mf_req = 1'($urandom_range(0, 1));
            issue(mdu_op_t'($urandom_range(0, 5)), a, b);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            #2 mf_req = 1'b0;
        end
        repeat (40) @(negedge clk);

        // Reset in the middle of a divide clears everything at once
        issue(MDU_MTLO, 32'hAAAA5555, 32'd0);
        issue(MDU_DIV, 32'd7, 32'd3);
        repeat (9) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        chk("rst_done", done, 0);
        @(negedge clk); #2 rst_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("rst_after_lo", lo, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
